ts_rx_decoder: RTL
==================

TS_RX_DECODER -- requirements
Module: ts_rx_decoder

Interface
REQ-001 SHALL have parameter CONSEC_REQ, default 8: number of consecutive identical TS needed to lock (legal range 2..15).
REQ-002 SHALL have parameter GAP_MAX, default 64: idle cycles without ts_i_vld before lock and count are dropped.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ts_i  input  128  received training set from the partner lane.
REQ-006 SHALL have port ts_i_vld  input  1  ts_i holds one complete TS this cycle.
REQ-007 SHALL have port clear  input  1  synchronous clear from the LTSSM on a state change.
REQ-008 SHALL have port ts1_locked  output  1  level: CONSEC_REQ identical TS1 received.
REQ-009 SHALL have port ts2_locked  output  1  level: CONSEC_REQ identical TS2 received.
REQ-010 SHALL have port lock_pulse  output  1  one-cycle pulse on entry to LOCKED.
REQ-011 SHALL have port bad_ts  output  1  one-cycle pulse on a malformed TS.
REQ-012 SHALL have port cnt  output  4  current consecutive-match count.
REQ-013 SHALL have port link_num, lane_num, n_fts, rate_id, train_ctrl  output  8 each  fields of the last accepted TS.

Function
REQ-014 SHALL decode ts_i as: [127:120] TS id, 0x4A = TS1 and 0x45 = TS2; [119:112] link number, 0xF7 = PAD; [111:104] lane number; [103:96] N_FTS; [95:88] rate id; [87:80] training control; [79:0] ignored.
REQ-015 SHALL treat a TS as malformed when its id is neither 0x4A nor 0x45.
REQ-016 SHALL compare bits [127:80] of each valid TS against the stored copy of the previous accepted TS.
REQ-017 SHALL implement the states IDLE, COUNT and LOCKED.
REQ-018 IDLE: a valid, well-formed TS SHALL store its fields, set cnt=1 and move to COUNT.
REQ-019 COUNT, matching TS: cnt SHALL increment; when cnt reaches CONSEC_REQ the block SHALL move to LOCKED.
REQ-020 COUNT or LOCKED, well-formed but non-matching TS: the block SHALL store the new fields, set cnt=1, enter COUNT and drop any lock.
REQ-021 LOCKED, matching TS: cnt SHALL saturate at CONSEC_REQ, the state SHALL hold and no new lock_pulse SHALL occur.
REQ-022 A malformed TS in any state SHALL pulse bad_ts, zero cnt, enter IDLE and drop the lock; the stored fields SHALL hold.
REQ-023 ts1_locked SHALL be high in LOCKED when the stored id is TS1; ts2_locked likewise for TS2; the two SHALL never both be high.
REQ-024 All outputs SHALL be registered; lock_pulse and ts*_locked SHALL assert the cycle after the clock edge that samples the CONSEC_REQ-th matching TS.
REQ-025 A gap counter SHALL count cycles with ts_i_vld low and reset on every vld. On reaching GAP_MAX it SHALL return the block to IDLE with cnt=0 and the lock dropped. The counter SHALL saturate.
REQ-026 clear SHALL act as reset for the state, cnt, gap counter and locks, but SHALL leave the field registers unchanged. clear SHALL take priority over a coincident ts_i_vld, and that TS SHALL be discarded.
REQ-027 No TS SHALL be lost on back-to-back ts_i_vld; one TS SHALL be processed per cycle.

Reset
REQ-028 On rst: state=IDLE, cnt=0, gap counter=0, all pulses and locks 0, all field outputs 0x00.
REQ-029 rst SHALL take priority over clear and ts_i_vld; reset mid-count SHALL discard partial progress.

Verification
REQ-030 8 back-to-back TS1 with link 0xF7 and lane 0x00 -> ts1_locked=1 and lock_pulse=1 one cycle after the 8th TS; cnt=8; link_num=0xF7.
REQ-031 7 TS1 followed by 1 TS2 -> no lock, cnt=1, stored id TS2; 7 further TS2 -> ts2_locked=1.
REQ-032 Locked on TS1, then a TS with id 0x00 -> bad_ts pulse, ts1_locked=0, cnt=0, link_num unchanged.
REQ-033 Locked, then 64 cycles without vld -> lock dropped at the 64th idle cycle; 63 idle cycles followed by a matching TS -> lock held.
REQ-034 clear asserted in the same cycle as the 8th TS1 -> no lock, cnt=0; rst after 5 TS1 -> cnt=0 and all fields 0x00.

Source files
------------

// File: rtl/ts_rx_decoder.sv
// ts_rx_decoder: watches received training sets on one lane and reports
// when CONSEC_REQ identical TS1 or TS2 sets have arrived back to back.
// Also captures the link/lane/N_FTS/rate/control fields of the last accepted TS.
module ts_rx_decoder #(
  parameter int CONSEC_REQ = 8,
  parameter int GAP_MAX    = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] ts_i,
  input  logic         ts_i_vld,
  input  logic         clear,
  output logic         ts1_locked,
  output logic         ts2_locked,
  output logic         lock_pulse,
  output logic         bad_ts,
  output logic [3:0]   cnt,
  output logic [7:0]   link_num,
  output logic [7:0]   lane_num,
  output logic [7:0]   n_fts,
  output logic [7:0]   rate_id,
  output logic [7:0]   train_ctrl
);

  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;
  localparam int         GAP_W  = $clog2(GAP_MAX + 1);
  localparam logic [3:0] CNT_LOCK = 4'(CONSEC_REQ);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [47:0]        hdr_q, hdr_d;   // stored TS bits [127:80]
  logic               ts1_locked_q, ts1_locked_d;
  logic               ts2_locked_q, ts2_locked_d;
  logic               lock_pulse_q, lock_pulse_d;
  logic               bad_ts_q, bad_ts_d;

  logic               well_formed;
  logic               hdr_match;
  logic               gap_expire;
  logic               unused_payload;

  // Bits [79:0] carry symbols this block does not interpret.
  assign unused_payload = ^ts_i[79:0];

  assign well_formed = (ts_i[127:120] == TS1_ID) || (ts_i[127:120] == TS2_ID);
  assign hdr_match   = (ts_i[127:80] == hdr_q);
  // The idle cycle being sampled now is the GAP_MAX-th one in a row.
  assign gap_expire  = !ts_i_vld && (gap_q >= GAP_W'(GAP_MAX - 1));

  // State register: all state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      gap_q        <= '0;
      hdr_q        <= '0;
      ts1_locked_q <= 1'b0;
      ts2_locked_q <= 1'b0;
      lock_pulse_q <= 1'b0;
      bad_ts_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      hdr_q        <= hdr_d;
      ts1_locked_q <= ts1_locked_d;
      ts2_locked_q <= ts2_locked_d;
      lock_pulse_q <= lock_pulse_d;
      bad_ts_q     <= bad_ts_d;
    end
  end

  // Next-state: match counting, field capture and idle-gap timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    if (ts_i_vld) begin
      gap_d = '0;
    end else if (gap_q != GAP_W'(GAP_MAX)) begin
      gap_d = gap_q + GAP_W'(1);
    end else begin
      gap_d = gap_q;
    end

    if (clear) begin
      // A TS arriving together with clear is dropped on purpose.
      state_d = S_IDLE;
      cnt_d   = '0;
      gap_d   = '0;
    end else if (ts_i_vld) begin
      if (!well_formed) begin
        // Malformed TS: restart, but keep the last good fields visible.
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          S_COUNT: begin
            if (hdr_match) begin
              cnt_d = cnt_q + 4'd1;
              if (cnt_q + 4'd1 == CNT_LOCK) begin
                state_d = S_LOCKED;
              end
            end else begin
              hdr_d   = ts_i[127:80];
              cnt_d   = 4'd1;
              state_d = S_COUNT;
            end
          end
          S_LOCKED: begin
            if (hdr_match) begin
              cnt_d = CNT_LOCK;
            end else begin
              hdr_d   = ts_i[127:80];
              cnt_d   = 4'd1;
              state_d = S_COUNT;
            end
          end
          default: begin
            hdr_d   = ts_i[127:80];
            cnt_d   = 4'd1;
            state_d = S_COUNT;
          end
        endcase
      end
    end else if (gap_expire) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Output decode: values the registered outputs take after this edge.
  always_comb begin
    ts1_locked_d = (state_d == S_LOCKED) && (hdr_d[47:40] == TS1_ID);
    ts2_locked_d = (state_d == S_LOCKED) && (hdr_d[47:40] == TS2_ID);
    lock_pulse_d = (state_d == S_LOCKED) && (state_q != S_LOCKED);
    bad_ts_d     = ts_i_vld && !clear && !well_formed;
  end

  assign ts1_locked = ts1_locked_q;
  assign ts2_locked = ts2_locked_q;
  assign lock_pulse = lock_pulse_q;
  assign bad_ts     = bad_ts_q;
  assign cnt        = cnt_q;
  assign link_num   = hdr_q[39:32];
  assign lane_num   = hdr_q[31:24];
  assign n_fts      = hdr_q[23:16];
  assign rate_id    = hdr_q[15:8];
  assign train_ctrl = hdr_q[7:0];

endmodule
